// File: rtl/banco_wb_arbiter.sv
// Round-robin write-back arbiter for the register bank write port (regC/dado/RW).
// Optional build macro ZERO_REG_EN makes register 0 read-only (granted, never written).
module banco_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]           regC,
  output logic [DATA_W-1:0]           dado,
  output logic                        RW,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [2**ADDR_W-1:0]        pend_mask
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] regc_q, regc_d;
  logic [DATA_W-1:0] dado_q, dado_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic [ADDR_W-1:0] reg_arr  [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_wr;
  int                scan_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign reg_arr[g]  = req_reg[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Scan from the round-robin pointer; the first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    req_ready = '0;
    if (rst_n && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!grant_vld && req_valid[ID_W'(scan_idx)]) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(scan_idx);
        end
      end
      if (grant_vld) begin
        req_ready[grant_idx] = 1'b1;
      end
    end
  end

`ifdef ZERO_REG_EN
  assign grant_wr = (reg_arr[grant_idx] != '0);
`else
  assign grant_wr = 1'b1;
`endif

  always_comb begin
    ptr_d      = ptr_q;
    rw_d       = 1'b0;
    regc_d     = regc_q;
    dado_d     = dado_q;
    grant_id_d = grant_id_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (grant_wr) begin
        rw_d       = 1'b1;
        regc_d     = reg_arr[grant_idx];
        dado_d     = data_arr[grant_idx];
        grant_id_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      regc_q     <= '0;
      dado_q     <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      regc_q     <= regc_d;
      dado_q     <= dado_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Outstanding writes: anything requesting plus the write currently on the port.
  always_comb begin
    pend_mask = '0;
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[ID_W'(i)]) begin
          pend_mask[reg_arr[ID_W'(i)]] = 1'b1;
        end
      end
      if (rw_q) begin
        pend_mask[regc_q] = 1'b1;
      end
    end
`ifdef ZERO_REG_EN
    pend_mask[0] = 1'b0;
`endif
  end

  assign regC     = regc_q;
  assign dado     = dado_q;
  assign RW       = rw_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_banco_wb_arbiter.sv
// Bench for banco_wb_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural round-robin model.
module tb_banco_wb_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_reg = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   regC;
  logic [DW-1:0]   dado;
  logic            RW;
  logic [0:0]      grant_id;
  logic [15:0]     pend_mask;

  int checks = 0;
  int failures = 0;

  banco_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .regC(regC), .dado(dado), .RW(RW),
    .grant_id(grant_id), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pointer plus the value last written to the bank port.
  int            m_ptr;
  logic          m_rw;
  logic [AW-1:0] m_regc;
  logic [DW-1:0] m_dado;
  int            m_gid;
  logic [N-1:0]  pend_prev = '0;

  function automatic int pick();
    if (!rst_n || hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] exp_pend();
    logic [15:0] p;
    p = '0;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) p[req_reg[i*AW +: AW]] = 1'b1;
      end
      if (m_rw) p[m_regc] = 1'b1;
    end
`ifdef ZERO_REG_EN
    p[0] = 1'b0;
`endif
    return p;
  endfunction

  function automatic bit writable(input logic [AW-1:0] r);
`ifdef ZERO_REG_EN
    return r != '0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr  <= 0;
      m_rw   <= 1'b0;
      m_regc <= '0;
      m_dado <= '0;
      m_gid  <= 0;
    end else if (pick() >= 0) begin
      m_ptr <= (pick() + 1) % N;
      if (writable(req_reg[pick()*AW +: AW])) begin
        m_rw   <= 1'b1;
        m_regc <= req_reg[pick()*AW +: AW];
        m_dado <= req_data[pick()*DW +: DW];
        m_gid  <= pick();
      end else begin
        m_rw <= 1'b0;
      end
    end else begin
      m_rw <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("m_ready", req_ready, exp_ready());
    chk("m_rw", RW, m_rw);
    chk("m_regc", regC, m_regc);
    chk("m_dado", dado, m_dado);
    chk("m_gid", grant_id, m_gid);
    chk("m_pend", pend_mask, exp_pend());
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (pend_prev[i]) chk("valid_held", req_valid[i], 1'b1);
      end
    end
    pend_prev <= rst_n ? (req_valid & ~exp_ready()) : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with both requesting
    #1;
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_reg = {4'd4, 4'd3};
    req_data = {16'h2222, 16'h1111};
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rw", RW, 1'b0);
    chk("rst_regc", regC, 4'd0);
    chk("rst_dado", dado, 16'h0);
    chk("rst_gid", grant_id, 1'b0);
    chk("rst_pend", pend_mask, 16'h0);
    tick(); tick();
    req_valid = 2'b00;
    rst_n = 1'b1;

    // 2: single write
    req_reg[3:0] = 4'd5;
    req_data[15:0] = 16'hBEEF;
    req_valid = 2'b01;
    #1 chk("t2_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t2_rw", RW, 1'b1);
    chk("t2_regc", regC, 4'd5);
    chk("t2_dado", dado, 16'hBEEF);
    chk("t2_gid", grant_id, 1'b0);
    chk("t2_pend", pend_mask, 16'h0020);
    tick();
    #1;
    chk("t2_rw_off", RW, 1'b0);
    chk("t2_pend_off", pend_mask, 16'h0);

    // 3: alternating grants from ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_reg = {4'd2, 4'd1};
    req_data = {16'hB2B2, 16'hA1A1};
    req_valid = 2'b11;
    #1 chk("t3_ready0", req_ready, 2'b01);
    tick();
    #1;
    chk("t3_ready1", req_ready, 2'b10);
    chk("t3_rw1", RW, 1'b1);
    chk("t3_regc1", regC, 4'd1);
    chk("t3_gid1", grant_id, 1'b0);
    tick();
    #1;
    chk("t3_ready2", req_ready, 2'b01);
    chk("t3_rw2", RW, 1'b1);
    chk("t3_regc2", regC, 4'd2);
    chk("t3_dado2", dado, 16'hB2B2);
    chk("t3_gid2", grant_id, 1'b1);
    tick();
    #1 chk("t3_regc3", regC, 4'd1);
    tick();
    req_valid = 2'b01;
    #1 chk("t3_regc4", regC, 4'd2);
    tick();
    req_valid = 2'b00;
    #1 chk("t3_rw5", RW, 1'b1);

    // 4: reset drops the in-flight write, then same target twice
    rst_n = 1'b0;
    #1;
    chk("t4_rst_rw", RW, 1'b0);
    chk("t4_rst_regc", regC, 4'd0);
    tick();
    rst_n = 1'b1;
    req_reg = {4'd7, 4'd7};
    req_data = {16'h0002, 16'h0001};
    req_valid = 2'b11;
    #1;
    chk("t4_ready0", req_ready, 2'b01);
    chk("t4_pend0", pend_mask, 16'h0080);
    tick();
    req_valid = 2'b10;
    #1;
    chk("t4_ready1", req_ready, 2'b10);
    chk("t4_dado1", dado, 16'h0001);
    chk("t4_pend1", pend_mask, 16'h0080);
    tick();
    req_valid = 2'b00;
    #1;
    chk("t4_rw2", RW, 1'b1);
    chk("t4_dado2", dado, 16'h0002);
    chk("t4_gid2", grant_id, 1'b1);
    chk("t4_pend2", pend_mask, 16'h0080);
    tick();
    #1;
    chk("t4_rw3", RW, 1'b0);
    chk("t4_pend3", pend_mask, 16'h0);
    chk("t4_dado3", dado, 16'h0002);

    // 5: hold freezes arbitration
    hold = 1'b1;
    req_reg[7:4] = 4'd9;
    req_data[31:16] = 16'h3333;
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_hold_ready", req_ready, 2'b00);
      chk("t5_hold_rw", RW, 1'b0);
      chk("t5_hold_pend", pend_mask, 16'h0200);
      tick();
    end
    hold = 1'b0;
    #1 chk("t5_ready", req_ready, 2'b10);
    tick();
    hold = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("t5_rw", RW, 1'b1);
    chk("t5_regc", regC, 4'd9);
    chk("t5_dado", dado, 16'h3333);
    chk("t5_gid", grant_id, 1'b1);
    tick();
    #1;
    chk("t5_rw_off", RW, 1'b0);
    chk("t5_regc_hold", regC, 4'd9);
    hold = 1'b0;

    // 6: write to register 0
    req_reg[3:0] = 4'd0;
    req_data[15:0] = 16'hFFFF;
    req_valid = 2'b01;
    #1;
    chk("t6_ready", req_ready, 2'b01);
`ifdef ZERO_REG_EN
    chk("t6_pend", pend_mask, 16'h0);
`else
    chk("t6_pend", pend_mask, 16'h0001);
`endif
    tick();
    req_valid = 2'b00;
    #1;
`ifdef ZERO_REG_EN
    chk("t6_rw", RW, 1'b0);
    chk("t6_regc", regC, 4'd9);
    chk("t6_dado", dado, 16'h3333);
    chk("t6_pend_after", pend_mask, 16'h0);
`else
    chk("t6_rw", RW, 1'b1);
    chk("t6_regc", regC, 4'd0);
    chk("t6_dado", dado, 16'hFFFF);
    chk("t6_gid", grant_id, 1'b0);
    chk("t6_pend_after", pend_mask, 16'h0001);
`endif

    // pointer advanced past requester 0 either way
    req_reg = {4'd3, 4'd2};
    req_valid = 2'b11;
    #1 chk("t6_ptr", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
